mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer.sv | 117 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Steps the 3-bit mux select through codes 0..7, samples mux_out at each code and
// delivers the packed frame over valid/ready. Optional macro: MUX_SCAN_CONTINUOUS_EN (free-running scans).
module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mux_out,
   output logic [2:0] sel,
   output logic [7:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       frame_changed,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

   // With no settle time each select code goes straight to its sample cycle.
   localparam state_t     scan_first  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
   localparam logic [3:0] settle_last = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

   state_t     state_reg;
   logic [3:0] cnt_reg;
   logic [7:0] shadow_reg;
   logic [7:0] shadow_next;
   logic [7:0] last_reg;
   logic       auto_start;
   logic       go;

`ifdef MUX_SCAN_CONTINUOUS_EN
   assign auto_start = 1'b1;
`else
   assign auto_start = 1'b0;
`endif

   assign go = start | auto_start;

   // Shadow frame with the bit for the current select replaced by the live mux output.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
         assign shadow_next[gi] = (sel == 3'(gi)) ? mux_out : shadow_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         shadow_reg    <= 8'd0;
         last_reg      <= 8'd0;
         sel           <= 3'd0;
         frame         <= 8'd0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               sel        <= 3'd0;
               shadow_reg <= 8'd0;
               if (go) begin
                  state_reg <= scan_first;
                  cnt_reg   <= 4'd0;
                  busy      <= 1'b1;
               end
            end

            SETTLE: begin
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == settle_last) begin
                  state_reg <= SAMPLE;
               end
            end

            SAMPLE: begin
               shadow_reg <= shadow_next;
               if (sel != 3'd7) begin
                  sel       <= sel + 3'd1;
                  cnt_reg   <= 4'd0;
                  state_reg <= scan_first;
               end else begin
                  frame         <= shadow_next;
                  frame_changed <= (shadow_next != last_reg);
                  frame_valid   <= 1'b1;
                  state_reg     <= HOLD;
               end
            end

            HOLD: begin
               if (frame_ready) begin
                  last_reg      <= frame;
                  frame_valid   <= 1'b0;
                  frame_changed <= 1'b0;
                  sel           <= 3'd0;
                  if (go) begin
                     // Back-to-back scan: restart without passing through IDLE.
                     state_reg  <= scan_first;
                     cnt_reg    <= 4'd0;
                     shadow_reg <= 8'd0;
                  end else begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: one instance with one settle cycle and one with none,
// each checked against a frame/latency model derived from the pad pattern.
module tb_mux_scan_sequencer;

   localparam int S_A = 1;
   localparam int S_B = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start_a, ready_a, start_b, ready_b;
   logic [7:0] pads_a, pads_b;
   logic       mux_a, mux_b;
   logic [2:0] sel_a, sel_b;
   logic [7:0] frame_a, frame_b;
   logic       valid_a, valid_b, changed_a, changed_b, busy_a, busy_b;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] last_a, last_b;

   // Behavioural 8-to-1 mux in front of each sequencer.
   assign mux_a = pads_a[sel_a];
   assign mux_b = pads_b[sel_b];

   mux_scan_sequencer #(.SETTLE_CYCLES(S_A)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mux_out(mux_a), .sel(sel_a),
      .frame(frame_a), .frame_valid(valid_a), .frame_ready(ready_a),
      .frame_changed(changed_a), .busy(busy_a)
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(S_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mux_out(mux_b), .sel(sel_b),
      .frame(frame_b), .frame_valid(valid_b), .frame_ready(ready_b),
      .frame_changed(changed_b), .busy(busy_b)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
      pads_a = 8'h00; pads_b = 8'h00;
      tick; tick;
      n_checks++;
      if (sel_a !== 3'd0 || frame_a !== 8'h00) begin
         n_fail++; $display("FAIL reset_a sel=%0d frame=%h exp sel=0 frame=00", sel_a, frame_a);
      end
      n_checks++;
      if (valid_a !== 1'b0 || changed_a !== 1'b0 || busy_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_a_flags v=%b c=%b b=%b exp 000", valid_a, changed_a, busy_a);
      end
      n_checks++;
      if (sel_b !== 3'd0 || frame_b !== 8'h00 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_b sel=%0d frame=%h v=%b b=%b exp 0/00/0/0", sel_b, frame_b, valid_b, busy_b);
      end
      reset = 1'b0;
      last_a = 8'h00; last_b = 8'h00;
      tick;
   endtask

   // One complete scan on instance A; frame after handshake stall, optional ignored-input noise.
   task automatic run_scan_a(input logic [7:0] pat, input int stall, input bit noise);
      int         lat;
      int         exp_sel;
      logic       exp_changed;
      lat = 8 * (S_A + 1);
      pads_a = pat; start_a = 1'b1;
      tick;
      start_a = 1'b0;
      for (int k = 0; k < lat; k++) begin
         exp_sel = k / (S_A + 1);
         if (exp_sel > 7) exp_sel = 7;
         n_checks++;
         if (sel_a !== 3'(exp_sel) || busy_a !== 1'b1 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_step k=%0d sel=%0d busy=%b valid=%b exp sel=%0d busy=1 valid=0",
                     k, sel_a, busy_a, valid_a, exp_sel);
         end
         if (noise) begin
            start_a = 1'($urandom_range(0, 1));
            ready_a = 1'($urandom_range(0, 1));
         end
         tick;
      end
      start_a = 1'b0; ready_a = 1'b0;
      exp_changed = (pat != last_a);
      n_checks++;
      if (valid_a !== 1'b1 || frame_a !== pat || changed_a !== exp_changed || sel_a !== 3'd7) begin
         n_fail++;
         $display("FAIL frame_out valid=%b frame=%h changed=%b sel=%0d exp valid=1 frame=%h changed=%b sel=7",
                  valid_a, frame_a, changed_a, sel_a, pat, exp_changed);
      end
      for (int s = 0; s < stall; s++) begin
         if (noise) start_a = 1'($urandom_range(0, 1));
         tick;
         n_checks++;
         if (valid_a !== 1'b1 || frame_a !== pat || changed_a !== exp_changed || sel_a !== 3'd7 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL stall s=%0d valid=%b frame=%h changed=%b sel=%0d exp 1/%h/%b/7",
                     s, valid_a, frame_a, changed_a, sel_a, pat, exp_changed);
         end
      end
      start_a = 1'b0; ready_a = 1'b1;
      tick;
      ready_a = 1'b0;
      n_checks++;
      if (valid_a !== 1'b0 || changed_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 3'd0 || frame_a !== pat) begin
         n_fail++;
         $display("FAIL handshake valid=%b changed=%b busy=%b sel=%0d frame=%h exp 0/0/0/0/%h",
                  valid_a, changed_a, busy_a, sel_a, frame_a, pat);
      end
      last_a = pat;
      $display("scan pattern=%h stall=%0d frame=%h changed=%b", pat, stall, frame_a, exp_changed);
   endtask

   task automatic test_scan_basic;
      run_scan_a(8'hA5, 0, 1'b0);
   endtask

   task automatic test_repeat;
      run_scan_a(8'hA5, 0, 1'b0);
      run_scan_a(8'hAD, 0, 1'b0);
   endtask

   task automatic test_stall;
      run_scan_a(8'hA5, 20, 1'b1);
   endtask

   task automatic test_reset_midscan;
      pads_a = 8'h5A; start_a = 1'b1;
      tick;
      start_a = 1'b0;
      repeat (4 * (S_A + 1)) tick;
      n_checks++;
      if (sel_a !== 3'd4) begin
         n_fail++; $display("FAIL midscan_sel sel=%0d exp 4", sel_a);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      n_checks++;
      if (sel_a !== 3'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || frame_a !== 8'h00) begin
         n_fail++;
         $display("FAIL midscan_reset sel=%0d busy=%b valid=%b frame=%h exp 0/0/0/00", sel_a, busy_a, valid_a, frame_a);
      end
      $display("reset mid-scan sel=%0d busy=%b frame=%h", sel_a, busy_a, frame_a);
      last_a = 8'h00; last_b = 8'h00;
      run_scan_a(8'h3C, 0, 1'b0);
   endtask

   task automatic test_random;
      logic [7:0] pat;
      for (int i = 0; i < 8; i++) begin
         pat = ($urandom_range(0, 2) == 0) ? last_a : 8'($urandom);
         run_scan_a(pat, int'($urandom_range(0, 5)), 1'b1);
      end
   endtask

   task automatic test_back_to_back;
      pads_b = 8'hFF; start_b = 1'b1;
      tick;
      start_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (sel_b !== 3'(k) || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first k=%0d sel=%0d busy=%b exp sel=%0d busy=1", k, sel_b, busy_b, k);
         end
         tick;
      end
      n_checks++;
      if (valid_b !== 1'b1 || frame_b !== 8'hFF || changed_b !== (8'hFF != last_b)) begin
         n_fail++; $display("FAIL b2b_frame1 valid=%b frame=%h changed=%b exp 1/ff/1", valid_b, frame_b, changed_b);
      end
      $display("b2b frame1 frame=%h changed=%b", frame_b, changed_b);
      last_b = 8'hFF;
      ready_b = 1'b1; start_b = 1'b1;
      tick;
      ready_b = 1'b0; start_b = 1'b0;
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (sel_b !== 3'(k) || busy_b !== 1'b1 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second k=%0d sel=%0d busy=%b valid=%b exp sel=%0d busy=1 valid=0",
                     k, sel_b, busy_b, valid_b, k);
         end
         tick;
      end
      n_checks++;
      if (valid_b !== 1'b1 || frame_b !== 8'hFF || changed_b !== 1'b0) begin
         n_fail++; $display("FAIL b2b_frame2 valid=%b frame=%h changed=%b exp 1/ff/0", valid_b, frame_b, changed_b);
      end
      $display("b2b frame2 frame=%h changed=%b", frame_b, changed_b);
      ready_b = 1'b1;
      tick;
      ready_b = 1'b0;
      n_checks++;
      if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
         n_fail++; $display("FAIL b2b_idle busy=%b valid=%b exp 0/0", busy_b, valid_b);
      end
   endtask

   task automatic test_continuous;
      int qa[$];
      int qb[$];
      bit busy_bad;
      bit prev_a, prev_b;
      busy_bad = 1'b0; prev_a = 1'b0; prev_b = 1'b0;
      pads_a = 8'h96; pads_b = 8'h69;
      ready_a = 1'b1; ready_b = 1'b1;
      tick;
      for (int c = 0; c < 200; c++) begin
         tick;
         if (valid_a && !prev_a) qa.push_back(c);
         if (valid_b && !prev_b) qb.push_back(c);
         prev_a = valid_a; prev_b = valid_b;
         if (!busy_a || !busy_b) busy_bad = 1'b1;
      end
      n_checks++;
      if (busy_bad) begin
         n_fail++; $display("FAIL cont_busy dropped got 0 exp 1");
      end
      n_checks++;
      if (qa.size() < 4 || qb.size() < 4) begin
         n_fail++; $display("FAIL cont_count frames_a=%0d frames_b=%0d exp >=4", qa.size(), qb.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (qa[i] - qa[i-1] != 8 * (S_A + 1) + 1 || qb[i] - qb[i-1] != 8 * (S_B + 1) + 1) begin
               n_fail++;
               $display("FAIL cont_period i=%0d a=%0d b=%0d exp a=%0d b=%0d", i,
                        qa[i] - qa[i-1], qb[i] - qb[i-1], 8 * (S_A + 1) + 1, 8 * (S_B + 1) + 1);
            end
            $display("continuous frame %0d period_a=%0d period_b=%0d", i, qa[i] - qa[i-1], qb[i] - qb[i-1]);
         end
      end
   endtask

   initial begin
      test_reset;
`ifdef MUX_SCAN_CONTINUOUS_EN
      test_continuous;
`else
      test_scan_basic;
      test_repeat;
      test_stall;
      test_reset_midscan;
      test_random;
      test_back_to_back;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
